// File: rtl/peripheral_spram_arbiter_wb.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_spram_arbiter_wb
// Description : Two-master Wishbone arbiter in front of one SPRAM slave port.
//               One master owns the slave for a whole Wishbone cycle (cyc
//               high). Ties are broken round-robin. Bursts are never
//               preempted. A per-access watchdog ends stalled accesses with
//               err.
// Ports       : wb_clk_i / wb_rst_ni  clock, async active-low reset
//               m0_wb_* / m1_wb_*     master request (in) and response (out)
//               s_wb_*                muxed request to slave, slave response
//               grant_o               one-hot current grant {m1, m0}
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_spram_arbiter_wb #(
   parameter int AW      = 10,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   // master 0
   input  logic [AW-1:0]   m0_wb_adr_i,
   input  logic [DW-1:0]   m0_wb_dat_i,
   input  logic [DW/8-1:0] m0_wb_sel_i,
   input  logic            m0_wb_we_i,
   input  logic            m0_wb_cyc_i,
   input  logic            m0_wb_stb_i,
   input  logic [2:0]      m0_wb_cti_i,
   input  logic [1:0]      m0_wb_bte_i,
   output logic [DW-1:0]   m0_wb_dat_o,
   output logic            m0_wb_ack_o,
   output logic            m0_wb_err_o,
   // master 1
   input  logic [AW-1:0]   m1_wb_adr_i,
   input  logic [DW-1:0]   m1_wb_dat_i,
   input  logic [DW/8-1:0] m1_wb_sel_i,
   input  logic            m1_wb_we_i,
   input  logic            m1_wb_cyc_i,
   input  logic            m1_wb_stb_i,
   input  logic [2:0]      m1_wb_cti_i,
   input  logic [1:0]      m1_wb_bte_i,
   output logic [DW-1:0]   m1_wb_dat_o,
   output logic            m1_wb_ack_o,
   output logic            m1_wb_err_o,
   // slave
   output logic [AW-1:0]   s_wb_adr_o,
   output logic [DW-1:0]   s_wb_dat_o,
   output logic [DW/8-1:0] s_wb_sel_o,
   output logic            s_wb_we_o,
   output logic            s_wb_cyc_o,
   output logic            s_wb_stb_o,
   output logic [2:0]      s_wb_cti_o,
   output logic [1:0]      s_wb_bte_o,
   input  logic [DW-1:0]   s_wb_dat_i,
   input  logic            s_wb_ack_i,
   input  logic            s_wb_err_i,
   // debug
   output logic [1:0]      grant_o
);

   // A zero TIMEOUT still needs a 1-bit counter to keep the declarations legal.
   localparam int            CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);
   localparam logic          c_wd_en   = (TIMEOUT != 0);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_gnt0 = 2'd1;
   localparam logic [1:0] c_gnt1 = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic          r_last;
   logic [CW-1:0] r_wd_cnt;
   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_stb_req;
   logic          w_wd_fire;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle: begin
            if (m0_wb_cyc_i && m1_wb_cyc_i)
               w_state_nxt = r_last ? c_gnt0 : c_gnt1;
            else if (m0_wb_cyc_i)
               w_state_nxt = c_gnt0;
            else if (m1_wb_cyc_i)
               w_state_nxt = c_gnt1;
         end
         // The owner keeps the slave for as long as its cyc is high; on
         // release the waiting master is handed the bus with no idle cycle.
         c_gnt0: if (!m0_wb_cyc_i) w_state_nxt = m1_wb_cyc_i ? c_gnt1 : c_idle;
         c_gnt1: if (!m1_wb_cyc_i) w_state_nxt = m0_wb_cyc_i ? c_gnt0 : c_idle;
         default: w_state_nxt = c_idle;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= c_idle;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt == c_gnt0)
            r_last <= 1'b0;
         else if (w_state_nxt == c_gnt1)
            r_last <= 1'b1;
      end
   end

   assign w_gnt0  = (r_state == c_gnt0);
   assign w_gnt1  = (r_state == c_gnt1);
   assign grant_o = {w_gnt1, w_gnt0};

   // ---------------------------------------------------------------- watchdog
   assign w_stb_req = (w_gnt0 && m0_wb_stb_i) || (w_gnt1 && m1_wb_stb_i);
   assign w_wd_fire = c_wd_en && w_stb_req && (r_wd_cnt == c_timeout);

   // The fire cycle forces s_wb_stb_o low, which also clears the counter.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)
         r_wd_cnt <= '0;
      else if ((w_state_nxt != r_state) || !s_wb_stb_o || s_wb_ack_i || s_wb_err_i)
         r_wd_cnt <= '0;
      else if (c_wd_en)
         r_wd_cnt <= r_wd_cnt + CW'(1);
   end

   // ---------------------------------------------------------------- request mux
   always_comb begin
      s_wb_adr_o = '0;
      s_wb_dat_o = '0;
      s_wb_sel_o = '0;
      s_wb_we_o  = 1'b0;
      s_wb_cyc_o = 1'b0;
      s_wb_stb_o = 1'b0;
      s_wb_cti_o = '0;
      s_wb_bte_o = '0;
      if (w_gnt0) begin
         s_wb_adr_o = m0_wb_adr_i;
         s_wb_dat_o = m0_wb_dat_i;
         s_wb_sel_o = m0_wb_sel_i;
         s_wb_we_o  = m0_wb_we_i;
         s_wb_cyc_o = m0_wb_cyc_i;
         s_wb_stb_o = m0_wb_stb_i && !w_wd_fire;
         s_wb_cti_o = m0_wb_cti_i;
         s_wb_bte_o = m0_wb_bte_i;
      end else if (w_gnt1) begin
         s_wb_adr_o = m1_wb_adr_i;
         s_wb_dat_o = m1_wb_dat_i;
         s_wb_sel_o = m1_wb_sel_i;
         s_wb_we_o  = m1_wb_we_i;
         s_wb_cyc_o = m1_wb_cyc_i;
         s_wb_stb_o = m1_wb_stb_i && !w_wd_fire;
         s_wb_cti_o = m1_wb_cti_i;
         s_wb_bte_o = m1_wb_bte_i;
      end
   end

   // ---------------------------------------------------------------- responses
   // Read data is broadcast; ack/err are steered to the owner only, and
   // simultaneous ack and err from the slave are passed on unresolved.
   assign m0_wb_dat_o = s_wb_dat_i;
   assign m1_wb_dat_o = s_wb_dat_i;
   assign m0_wb_ack_o = w_gnt0 && s_wb_ack_i;
   assign m1_wb_ack_o = w_gnt1 && s_wb_ack_i;
   assign m0_wb_err_o = w_gnt0 && (s_wb_err_i || w_wd_fire);
   assign m1_wb_err_o = w_gnt1 && (s_wb_err_i || w_wd_fire);

endmodule
`default_nettype wire

// File: tb/tb_peripheral_spram_arbiter_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_spram_arbiter_wb
// Description : Directed self-checking bench for peripheral_spram_arbiter_wb
//               with a small registered-ack SPRAM model as the slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_spram_arbiter_wb;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] m0_adr = '0, m1_adr = '0;
   logic [DW-1:0] m0_dat = '0, m1_dat = '0;
   logic [3:0]    m0_sel = '0, m1_sel = '0;
   logic          m0_we = 1'b0, m1_we = 1'b0;
   logic          m0_cyc = 1'b0, m1_cyc = 1'b0;
   logic          m0_stb = 1'b0, m1_stb = 1'b0;
   logic [2:0]    m0_cti = '0, m1_cti = '0;
   logic [1:0]    m0_bte = '0, m1_bte = '0;
   logic [DW-1:0] m0_rdat, m1_rdat;
   logic          m0_ack, m1_ack, m0_err, m1_err;
   logic [AW-1:0] s_adr;
   logic [DW-1:0] s_wdat;
   logic [3:0]    s_sel;
   logic          s_we, s_cyc, s_stb;
   logic [2:0]    s_cti;
   logic [1:0]    s_bte;
   logic [DW-1:0] s_rdat = '0;
   logic          s_ack = 1'b0;
   logic          s_err = 1'b0;
   logic [1:0]    grant;

   logic          slave_en = 1'b1;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] wmask;

   int n_vec   = 0;
   int n_miss  = 0;
   int n_cross = 0;

   peripheral_spram_arbiter_wb #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
      .wb_clk_i   (clk),     .wb_rst_ni  (rst_n),
      .m0_wb_adr_i(m0_adr),  .m0_wb_dat_i(m0_dat),  .m0_wb_sel_i(m0_sel),
      .m0_wb_we_i (m0_we),   .m0_wb_cyc_i(m0_cyc),  .m0_wb_stb_i(m0_stb),
      .m0_wb_cti_i(m0_cti),  .m0_wb_bte_i(m0_bte),  .m0_wb_dat_o(m0_rdat),
      .m0_wb_ack_o(m0_ack),  .m0_wb_err_o(m0_err),
      .m1_wb_adr_i(m1_adr),  .m1_wb_dat_i(m1_dat),  .m1_wb_sel_i(m1_sel),
      .m1_wb_we_i (m1_we),   .m1_wb_cyc_i(m1_cyc),  .m1_wb_stb_i(m1_stb),
      .m1_wb_cti_i(m1_cti),  .m1_wb_bte_i(m1_bte),  .m1_wb_dat_o(m1_rdat),
      .m1_wb_ack_o(m1_ack),  .m1_wb_err_o(m1_err),
      .s_wb_adr_o (s_adr),   .s_wb_dat_o (s_wdat),  .s_wb_sel_o (s_sel),
      .s_wb_we_o  (s_we),    .s_wb_cyc_o (s_cyc),   .s_wb_stb_o (s_stb),
      .s_wb_cti_o (s_cti),   .s_wb_bte_o (s_bte),   .s_wb_dat_i (s_rdat),
      .s_wb_ack_i (s_ack),   .s_wb_err_i (s_err),
      .grant_o    (grant)
   );

   always #5 clk = ~clk;

   // SPRAM model: one-cycle registered ack, ack drops for a cycle between
   // back-to-back accesses. slave_en=0 models a hung slave.
   always_comb begin
      wmask = '0;
      for (int b = 0; b < 4; b++) if (s_sel[b]) wmask[8*b +: 8] = 8'hFF;
   end

   always @(posedge clk) begin
      if (s_cyc && s_stb && !s_ack && slave_en) begin
         s_ack <= 1'b1;
         if (s_we) mem[s_adr] <= (mem[s_adr] & ~wmask) | (s_wdat & wmask);
         else      s_rdat     <= mem[s_adr];
      end else begin
         s_ack <= 1'b0;
      end
   end

   // An ack may only reach the master that currently holds the grant.
   always @(negedge clk) begin
      if ((m0_ack && grant != 2'b01) || (m1_ack && grant != 2'b10))
         n_cross++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input int m, input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
         tick();
         seen = (m == 0) ? m0_ack : m1_ack;
      end
      check(tag, {31'd0, seen}, 32'd1);
   endtask

   initial begin
      for (int a = 0; a < (1<<AW); a++) mem[a] = '0;

      // ---- reset state
      tick(); tick();
      check("rst_grant", {30'd0, grant}, 32'h0);
      check("rst_s_stb", {31'd0, s_stb}, 32'h0);
      check("rst_s_cyc", {31'd0, s_cyc}, 32'h0);
      check("rst_m0_ack", {31'd0, m0_ack}, 32'h0);
      rst_n = 1'b1;
      tick();

      // ---- single master write then read of 0x004
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 10'h004;
      m0_dat = 32'hDEADBEEF; m0_sel = 4'hF;
      #1;
      check("first_stb_latency", {31'd0, s_stb}, 32'h0);
      tick();
      check("single_grant", {30'd0, grant}, 32'h1);
      check("single_s_stb", {31'd0, s_stb}, 32'h1);
      check("single_s_adr", {22'd0, s_adr}, 32'h4);
      check("single_s_dat", s_wdat, 32'hDEADBEEF);
      check("single_s_we", {31'd0, s_we}, 32'h1);
      wait_ack(0, "single_wr_ack");
      m0_we = 0;
      wait_ack(0, "single_rd_ack");
      check("single_rd_dat", m0_rdat, 32'hDEADBEEF);
      m0_cyc = 0; m0_stb = 0;
      tick();
      check("single_idle", {30'd0, grant}, 32'h0);

      // ---- tie straight out of reset: m0 first, then direct handover
      rst_n = 0; tick(); rst_n = 1; tick();
      m0_cyc = 1; m0_stb = 1; m0_adr = 10'h004;
      m1_cyc = 1; m1_stb = 1; m1_adr = 10'h008; m1_sel = 4'hF;
      tick();
      check("tie_first_grant", {30'd0, grant}, 32'h1);
      wait_ack(0, "tie_m0_ack");
      check("tie_m1_no_ack", {31'd0, m1_ack}, 32'h0);
      m0_cyc = 0; m0_stb = 0;
      tick();
      check("tie_handover", {30'd0, grant}, 32'h2);
      check("tie_handover_adr", {22'd0, s_adr}, 32'h8);
      wait_ack(1, "tie_m1_ack");
      m1_cyc = 0; m1_stb = 0;
      tick();

      // ---- round-robin: 4 single accesses per master, both always pending
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rr_grant", {30'd0, grant}, (i % 2 == 0) ? 32'h1 : 32'h2);
         if (i >= 1 && i <= 6) begin
            if (i % 2 == 1) begin m0_cyc = 1; m0_stb = 1; end
            else            begin m1_cyc = 1; m1_stb = 1; end
         end
         tick();
         if (i % 2 == 0) begin
            check("rr_m0_ack", {31'd0, m0_ack}, 32'h1);
            check("rr_m1_quiet", {31'd0, m1_ack}, 32'h0);
            m0_cyc = 0; m0_stb = 0;
         end else begin
            check("rr_m1_ack", {31'd0, m1_ack}, 32'h1);
            check("rr_m0_quiet", {31'd0, m0_ack}, 32'h0);
            m1_cyc = 0; m1_stb = 0;
         end
      end
      tick();
      check("rr_idle", {30'd0, grant}, 32'h0);

      // ---- burst hold: 8-beat m1 burst is not preempted by m0
      m1_cyc = 1; m1_stb = 1; m1_cti = 3'b010; m1_adr = 10'h010;
      tick();
      check("burst_grant_m1", {30'd0, grant}, 32'h2);
      check("burst_s_cti", {29'd0, s_cti}, 32'h2);
      m0_cyc = 1; m0_stb = 1; m0_adr = 10'h004;
      for (int b = 0; b < 8; b++) begin
         m1_adr = 10'h010 + 10'(b);
         m1_cti = (b == 7) ? 3'b111 : 3'b010;
         wait_ack(1, "burst_beat_ack");
         check("burst_hold", {30'd0, grant}, 32'h2);
      end
      m1_cyc = 0; m1_stb = 0; m1_cti = 3'b000;
      tick();
      check("burst_then_m0", {30'd0, grant}, 32'h1);
      wait_ack(0, "burst_m0_ack");
      m0_cyc = 0; m0_stb = 0;
      tick();

      // ---- watchdog: hung slave, TIMEOUT = 4
      slave_en = 0;
      m0_cyc = 1; m0_stb = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("wd_no_err", {31'd0, m0_err}, 32'h0);
         check("wd_stb_on", {31'd0, s_stb}, 32'h1);
      end
      tick();
      check("wd_err", {31'd0, m0_err}, 32'h1);
      check("wd_stb_forced_low", {31'd0, s_stb}, 32'h0);
      check("wd_m1_err_quiet", {31'd0, m1_err}, 32'h0);
      tick();
      check("wd_err_one_cycle", {31'd0, m0_err}, 32'h0);
      check("wd_stb_renewed", {31'd0, s_stb}, 32'h1);
      m0_cyc = 0; m0_stb = 0; slave_en = 1;
      tick();

      // ---- reset in the middle of a burst
      m1_cyc = 1; m1_stb = 1; m1_cti = 3'b010; m1_adr = 10'h020;
      tick(); tick(); tick();
      check("mrst_pre_grant", {30'd0, grant}, 32'h2);
      rst_n = 0;
      #1;
      check("mrst_grant", {30'd0, grant}, 32'h0);
      check("mrst_s_stb", {31'd0, s_stb}, 32'h0);
      check("mrst_s_cyc", {31'd0, s_cyc}, 32'h0);
      check("mrst_s_adr", {22'd0, s_adr}, 32'h0);
      check("mrst_s_cti", {29'd0, s_cti}, 32'h0);
      check("mrst_m1_ack", {31'd0, m1_ack}, 32'h0);
      check("mrst_m1_err", {31'd0, m1_err}, 32'h0);
      m0_cyc = 1; m0_stb = 1;
      tick(); tick();
      rst_n = 1;
      tick();
      check("mrst_tie_m0", {30'd0, grant}, 32'h1);
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; m1_cti = 3'b000;
      tick(); tick();

      check("no_cross_ack", n_cross, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/peripheral_spram_arbiter_wb.md
# peripheral_spram_arbiter_wb

Two-master Wishbone arbiter that shares one `peripheral_spram_wb` slave port between two bus masters, e.g. a CPU data port and a DMA/BFM transactor. It grants the slave to one master per Wishbone cycle (`cyc` high), with round-robin fairness and burst-aware grant hold (`cti`/`bte` passed through). A per-access ack-timeout watchdog terminates stalled accesses with `err`.

## Interface
Parameters:
- `AW`, 10, slave address width; matches the SPRAM `$clog2(DEPTH)`.
- `DW`, 32, data width; `sel` width is `DW/8`.
- `TIMEOUT`, 16, cycles of `stb` without ack before `err`; 0 disables the watchdog.

Ports (`mN` means each of `m0` and `m1`):
- `wb_clk_i`  in  1  single clock; all state updates on the rising edge.
- `wb_rst_ni`  in  1  reset, asynchronous and active-low.
- `mN_wb_adr_i`  in  AW  master address.
- `mN_wb_dat_i`  in  DW  master write data.
- `mN_wb_sel_i`  in  DW/8  byte selects.
- `mN_wb_we_i`  in  1  write enable.
- `mN_wb_cyc_i`  in  1  cycle request; grant is held while this is high.
- `mN_wb_stb_i`  in  1  strobe.
- `mN_wb_cti_i`  in  3  cycle type.
- `mN_wb_bte_i`  in  2  burst type.
- `mN_wb_dat_o`  out  DW  read data; the slave `dat` is broadcast to both masters.
- `mN_wb_ack_o`  out  1  ack; only the granted master sees it.
- `mN_wb_err_o`  out  1  slave error OR watchdog error, granted master only.
- `s_wb_adr_o`, `s_wb_dat_o`, `s_wb_sel_o`, `s_wb_we_o`, `s_wb_cyc_o`, `s_wb_stb_o`, `s_wb_cti_o`, `s_wb_bte_o`  out  (as master)  muxed request to the SPRAM.
- `s_wb_dat_i`  in  DW  slave read data.
- `s_wb_ack_i`  in  1  slave ack.
- `s_wb_err_i`  in  1  slave error.
- `grant_o`  out  2  one-hot current grant, for debug and coverage.

## Operation
- FSM states: `IDLE`, `GNT0`, `GNT1`. The state is registered.
  - Slave outputs are combinationally muxed from the granted master.
  - In `IDLE`, every slave output is 0.
- `last` register: holds the index of the last master granted. Reset value is 1, so `m0` wins the first tie.
- `IDLE` transitions:
  - Only `mX_cyc` high -> `GNTX`.
  - Both high -> grant the master != `last`.
  - Neither high -> stay in `IDLE`.
- `GNTX` transitions:
  - `mX_cyc` high -> stay. No preemption, including during bursts (`cti`=010).
  - `mX_cyc` low and the other master's `cyc` high -> go directly to the other grant. Handover takes no idle cycle.
  - `mX_cyc` low and the other master's `cyc` low -> `IDLE`.
  - On every entry to `GNTX`, set `last`=X.
- Ungranted master: `ack`=0 and `err`=0. Its request is never forwarded.
- Watchdog, counter width `$clog2(TIMEOUT+1)`:
  - Clears when `s_stb`=0, `s_ack`=1, `s_err`=1, or on a grant change.
  - Otherwise increments while `s_stb`=1.
  - On reaching `TIMEOUT`: assert `mX_err_o` for 1 cycle and force `s_stb_o`=0 in that cycle; the counter then clears.
  - The master must drop or renew `stb`.
- Simultaneous `s_ack` and `s_err` both pass through. The arbiter does not resolve them.

## Timing
- Reset (async assert, sync release):
  - State `IDLE`, `last`=1, counter 0.
  - All `s_*` outputs 0, all `mN_ack/err` 0, `grant_o`=00, immediately on assert.
- Reset asserted mid-transfer aborts the transfer silently; no ack or err is generated.
- First access from `IDLE`: the request is sampled at edge N, and `s_stb` is asserted in the cycle after edge N. This adds 1 cycle of latency.
- Accesses under a held grant, and handover: 0 added cycles.
- `ack`/`err`/`dat` return to the master combinationally in the same cycle as the slave responds.
- Watchdog `err` fires in the cycle after the `TIMEOUT`-th consecutive unacked `stb` cycle.

## Test plan
- **Single master:** `m0` writes 0xDEADBEEF to addr 0x004, then reads it back. Required: read data is 0xDEADBEEF, `grant_o`=01, and exactly 1 extra cycle before the first `s_stb`.
- **Tie from reset:** both `cyc` rise at the same edge after reset. Required: `m0` is granted first. When `m0` drops `cyc`, `grant_o` goes to 10 at the next edge with no `IDLE` cycle in between.
- **Round-robin:** both masters request continuously, each issuing 4 single-access cycles. Required: grants alternate 01,10,01,10,… and `m1_ack` is never asserted during an `m0` grant.
- **Burst hold:** `m1` runs an 8-beat incrementing burst (`cti`=010, last beat 111) while `m0` requests. Required: all 8 acks go to `m1` before `m0` is granted.
- **Watchdog:** with `TIMEOUT`=4, the slave `ack` is tied low. Required: `m0_err` is high for 1 cycle after 4 `stb` cycles, and `s_stb`=0 in that cycle.
- **Mid-burst reset:** pull `wb_rst_ni` low mid-burst. Required: all outputs are 0 asynchronously, and after release `m0` wins a tie.
